// File: rtl/benes4_feeder_pkg.sv
// rtl/benes4_feeder_pkg.sv - shared types and defaults for the 4-lane Benes feeder
package benes4_feeder_pkg;

  localparam int N_DEF = 32;  // data word width
  localparam int Q_DEF = 15;  // fractional bits; words are carried bit-exact, never interpreted
  localparam int M_DEF = 3;   // route-select width, one bit per network column
  localparam int LANES = 4;

  typedef logic [1:0] slot_t;

  // One complete group as presented to the network; lane[0] is x1
  typedef struct packed {
    logic [LANES-1:0][N_DEF-1:0] lane;
    logic [M_DEF-1:0]            sel;
    logic                        pad;
  } group_t;

endpackage

// File: rtl/benes4_group_fifo2.sv
// rtl/benes4_group_fifo2.sv - two-entry group FIFO with a registered head
module benes4_group_fifo2
  import benes4_feeder_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push_i,
  input  group_t push_data_i,
  input  logic   pop_i,
  output logic   full_o,
  output logic   empty_o,
  output group_t head_o
);

  logic [1:0] count_q;
  group_t     head_q;
  group_t     tail_q;
  logic       push_eff;
  logic       pop_eff;

  assign push_eff = push_i && (count_q != 2'd2);
  assign pop_eff  = pop_i && (count_q != 2'd0);
  assign full_o   = (count_q == 2'd2);
  assign empty_o  = (count_q == 2'd0);
  assign head_o   = head_q;

  // Head is always the oldest group; a push with a concurrent pop at occupancy 1 goes straight to head
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      if (pop_eff) begin
        if (count_q == 2'd2) head_q <= tail_q;
        else if (push_eff)   head_q <= push_data_i;
      end else if (push_eff) begin
        if (count_q == 2'd0) head_q <= push_data_i;
        else                 tail_q <= push_data_i;
      end
      if (push_eff && !pop_eff)      count_q <= count_q + 2'd1;
      else if (pop_eff && !push_eff) count_q <= count_q - 2'd1;
    end
  end

endmodule

// File: rtl/benes4_feeder.sv
// rtl/benes4_feeder.sv - packs a serial word stream into 4-lane groups for the Benes network
module benes4_feeder
  import benes4_feeder_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int M  = M_DEF,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  in_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_last,
  input  logic [M-1:0]  sel_in,
  output logic [N-1:0]  x1,
  output logic [N-1:0]  x2,
  output logic [N-1:0]  x3,
  output logic [N-1:0]  x4,
  output logic [M-1:0]  s,
  output logic          pad,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] groups_sent
);

  slot_t         slot_q;
  logic [N-1:0]  asm_q [3];
  logic [M-1:0]  sel_q;
  logic [CW-1:0] groups_sent_q;
  group_t        grp_d;
  group_t        head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          accept;
  logic          commit;
  logic          pop;

  // in_ready depends only on FIFO occupancy, so no path from in_valid/out_ready reaches it
  assign in_ready  = !fifo_full;
  assign out_valid = !fifo_empty;
  assign accept    = in_valid && in_ready;
  assign commit    = accept && ((slot_q == 2'd3) || in_last);
  assign pop       = out_valid && out_ready;

  // Build the committed group from stored lanes plus the current word; lanes above it stay zero
  always_comb begin
    grp_d = '0;
    for (int k = 0; k < 3; k++) begin
      if (k < int'(slot_q)) grp_d.lane[k] = asm_q[k];
    end
    grp_d.lane[slot_q] = in_data;
    grp_d.sel          = (slot_q == 2'd0) ? sel_in : sel_q;
    grp_d.pad          = in_last && (slot_q != 2'd3);
  end

  // Slot counter and assembly register; select is captured with the first word only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= 2'd0;
      sel_q  <= '0;
      for (int k = 0; k < 3; k++) asm_q[k] <= '0;
    end else if (accept) begin
      case (slot_q)
        2'd0:    asm_q[0] <= in_data;
        2'd1:    asm_q[1] <= in_data;
        2'd2:    asm_q[2] <= in_data;
        default: ;
      endcase
      if (slot_q == 2'd0) sel_q <= sel_in;
      slot_q <= commit ? 2'd0 : slot_q + 2'd1;
    end
  end

  // Popped-group counter, wraps naturally at 2^CW
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) groups_sent_q <= '0;
    else if (pop) groups_sent_q <= groups_sent_q + 1'b1;
  end

  benes4_group_fifo2 u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (commit),
    .push_data_i (grp_d),
    .pop_i       (pop),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .head_o      (head)
  );

  assign x1          = head.lane[0];
  assign x2          = head.lane[1];
  assign x3          = head.lane[2];
  assign x4          = head.lane[3];
  assign s           = head.sel;
  assign pad         = head.pad;
  assign groups_sent = groups_sent_q;

endmodule

// File: tb/tb_benes4_feeder.sv
// tb/tb_benes4_feeder.sv - directed self-checking bench for benes4_feeder
module tb_benes4_feeder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_last = 1'b0;
  logic [2:0]  sel_in = '0;
  logic [31:0] x1, x2, x3, x4;
  logic [2:0]  s;
  logic        pad;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] groups_sent;

  int checks = 0;
  int errors = 0;
  int accepted;
  logic [31:0] popped [$];

  benes4_feeder dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .sel_in(sel_in), .x1(x1), .x2(x2), .x3(x3), .x4(x4), .s(s), .pad(pad),
    .out_valid(out_valid), .out_ready(out_ready), .groups_sent(groups_sent)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          n;
    logic [31:0] w [4];
    logic [2:0]  sel;
    logic        last;
    logic [31:0] e [4];
    logic [2:0]  es;
    logic        epad;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_vec(input int idx, input int n, input logic [31:0] w0, w1, w2, w3,
                         input logic [2:0] sel, input logic last,
                         input logic [31:0] e0, e1, e2, e3, input logic [2:0] es, input logic epad);
    vecs[idx].n = n;
    vecs[idx].w[0] = w0; vecs[idx].w[1] = w1; vecs[idx].w[2] = w2; vecs[idx].w[3] = w3;
    vecs[idx].sel = sel; vecs[idx].last = last;
    vecs[idx].e[0] = e0; vecs[idx].e[1] = e1; vecs[idx].e[2] = e2; vecs[idx].e[3] = e3;
    vecs[idx].es = es; vecs[idx].epad = epad;
  endtask

  // Called at a negedge; returns at the negedge after the word was accepted
  task automatic push_word(input logic [31:0] d, input logic [2:0] sel, input logic last);
    int t = 0;
    in_data = d; sel_in = sel; in_last = last; in_valid = 1'b1;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: got in_ready=0 expected 1");
    end else begin
      @(negedge clk);
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One cycle of continuous streaming of words 0x100.. with pop bookkeeping
  task automatic stream_step();
    logic acc;
    if (accepted < 12) begin
      in_valid = 1'b1; in_data = 32'h100 + accepted; sel_in = 3'(accepted / 4); in_last = 1'b0;
    end else begin
      in_valid = 1'b0;
    end
    acc = in_valid && in_ready;
    if (out_valid && out_ready) popped.push_back(x1);
    @(negedge clk);
    if (acc) accepted++;
  endtask

  initial begin
    int exp_gs;
    int i;

    set_vec(0, 4, 32'h00080000, 32'h00100000, 32'h00180000, 32'h00200000, 3'b111, 1'b0,
            32'h00080000, 32'h00100000, 32'h00180000, 32'h00200000, 3'b111, 1'b0);
    set_vec(1, 2, 32'h00080000, 32'h00100000, 32'h0, 32'h0, 3'b101, 1'b1,
            32'h00080000, 32'h00100000, 32'h0, 32'h0, 3'b101, 1'b1);
    set_vec(2, 1, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 3'b010, 1'b1,
            32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 3'b010, 1'b1);
    set_vec(3, 3, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'hFFFFFFFF, 32'h0, 3'b001, 1'b1,
            32'hA5A5A5A5, 32'h5A5A5A5A, 32'hFFFFFFFF, 32'h0, 3'b001, 1'b1);
    set_vec(4, 4, 32'h11111111, 32'h22222222, 32'h33333333, 32'h80000001, 3'b110, 1'b1,
            32'h11111111, 32'h22222222, 32'h33333333, 32'h80000001, 3'b110, 1'b0);

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h1);
    check("rst_x1", x1, 32'h0);
    check("rst_groups_sent", 32'(groups_sent), 32'h0);
    rst_n = 1'b1;

    // Table-driven groups, consumer always ready
    out_ready = 1'b1;
    exp_gs = 0;
    for (int v = 0; v < 5; v++) begin
      for (int j = 0; j < vecs[v].n; j++)
        push_word(vecs[v].w[j], (j == 0) ? vecs[v].sel : ~vecs[v].sel,
                  (j == vecs[v].n - 1) && vecs[v].last);
      check($sformatf("v%0d_valid", v), 32'(out_valid), 32'h1);
      check($sformatf("v%0d_x1", v), x1, vecs[v].e[0]);
      check($sformatf("v%0d_x2", v), x2, vecs[v].e[1]);
      check($sformatf("v%0d_x3", v), x3, vecs[v].e[2]);
      check($sformatf("v%0d_x4", v), x4, vecs[v].e[3]);
      check($sformatf("v%0d_s", v), 32'(s), 32'(vecs[v].es));
      check($sformatf("v%0d_pad", v), 32'(pad), 32'(vecs[v].epad));
      exp_gs++;
      @(negedge clk);
      check($sformatf("v%0d_valid_gone", v), 32'(out_valid), 32'h0);
      check($sformatf("v%0d_groups_sent", v), 32'(groups_sent), 32'(exp_gs));
    end

    // Backpressure: 12 words offered with the consumer stalled
    do_reset();
    out_ready = 1'b0; accepted = 0; popped.delete();
    repeat (10) stream_step();
    check("bp_accepted", 32'(accepted), 32'd8);
    check("bp_in_ready_low", 32'(in_ready), 32'h0);
    check("bp_x1_hold", x1, 32'h100);
    check("bp_x4_hold", x4, 32'h103);
    repeat (2) stream_step();
    check("bp_x1_hold2", x1, 32'h100);
    check("bp_s_hold", 32'(s), 32'h0);
    out_ready = 1'b1;
    i = 0;
    while ((accepted < 12 || out_valid) && i < 40) begin
      stream_step();
      i++;
    end
    check("bp_pop_count", 32'(popped.size()), 32'd3);
    if (popped.size() == 3) begin
      check("bp_pop0", popped[0], 32'h100);
      check("bp_pop1", popped[1], 32'h104);
      check("bp_pop2", popped[2], 32'h108);
    end
    check("bp_groups_sent", 32'(groups_sent), 32'd3);

    // Push and pop in the same cycle at occupancy 1
    do_reset();
    out_ready = 1'b0;
    for (int j = 0; j < 4; j++) push_word(32'hA0 + j, 3'b011, 1'b0);
    for (int j = 0; j < 3; j++) push_word(32'hB0 + j, 3'b100, 1'b0);
    check("ov_head_a", x1, 32'hA0);
    out_ready = 1'b1;
    push_word(32'hB3, 3'b000, 1'b0);
    check("ov_valid", 32'(out_valid), 32'h1);
    check("ov_x1_b", x1, 32'hB0);
    check("ov_x4_b", x4, 32'hB3);
    check("ov_s_b", 32'(s), 32'b100);
    check("ov_gs1", 32'(groups_sent), 32'd1);
    @(negedge clk);
    check("ov_empty", 32'(out_valid), 32'h0);
    check("ov_gs2", 32'(groups_sent), 32'd2);

    // Asynchronous reset mid-group with a group buffered
    do_reset();
    out_ready = 1'b1;
    push_word(32'h77, 3'b001, 1'b1);
    @(negedge clk);
    out_ready = 1'b0;
    for (int j = 0; j < 4; j++) push_word(32'hC0 + j, 3'b010, 1'b0);
    for (int j = 0; j < 2; j++) push_word(32'hD0 + j, 3'b011, 1'b0);
    check("rs_pre_valid", 32'(out_valid), 32'h1);
    check("rs_pre_gs", 32'(groups_sent), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rs_valid", 32'(out_valid), 32'h0);
    check("rs_x1", x1, 32'h0);
    check("rs_x4", x4, 32'h0);
    check("rs_s", 32'(s), 32'h0);
    check("rs_gs", 32'(groups_sent), 32'h0);
    check("rs_in_ready", 32'(in_ready), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int j = 0; j < 4; j++) push_word(32'hE0 + j, 3'b110, 1'b0);
    check("rs_new_x1", x1, 32'hE0);
    check("rs_new_x2", x2, 32'hE1);
    check("rs_new_x3", x3, 32'hE2);
    check("rs_new_x4", x4, 32'hE3);
    check("rs_new_pad", 32'(pad), 32'h0);
    check("rs_new_gs0", 32'(groups_sent), 32'h0);
    @(negedge clk);
    check("rs_new_gs1", 32'(groups_sent), 32'd1);

    // Counter wrap: 65535 single-word groups, then one more
    do_reset();
    out_ready = 1'b1; accepted = 0; i = 0;
    in_data = 32'h5; sel_in = 3'b0; in_last = 1'b1;
    while (accepted < 65535 && i < 70000) begin
      logic acc;
      in_valid = 1'b1;
      acc = in_ready;
      @(negedge clk);
      if (acc) accepted++;
      i++;
    end
    in_valid = 1'b0; in_last = 1'b0;
    repeat (3) @(negedge clk);
    check("wrap_pre", 32'(groups_sent), 32'hFFFF);
    push_word(32'h9, 3'b0, 1'b1);
    @(negedge clk);
    check("wrap_zero", 32'(groups_sent), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
